// File: rtl/shift_seq_ctrl_pkg.sv
// Shared types for the shift sequencer: shift modes, FSM states and the counter-width helper.
// Purely declarative, so there is no latency or backpressure to describe.
package shift_pkg;

  typedef enum logic [1:0] {
    LSR = 2'b00,
    ASR = 2'b01,
    LSL = 2'b10,
    ROR = 2'b11
  } shift_mode_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } shift_state_t;

  // The counter must hold both the clamp value (width) and the largest raw rotate amount.
  function automatic int cnt_width(input int width, input int amt_w);
    int max_amt;
    max_amt = (1 << amt_w) - 1;
    if (width > max_amt) max_amt = width;
    return $clog2(max_amt + 1);
  endfunction

endpackage

// File: rtl/shift_seq_ctrl_if.sv
// Request/result bundle between the issuing logic (master) and the shift sequencer (slave).
// start_valid/start_ready handshake; the result is qualified by the one-cycle done pulse.
interface shift_seq_ctrl_if #(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
);
  logic             start_valid;
  logic             start_ready;
  logic [WIDTH-1:0] din;
  logic [AMT_W-1:0] amt;
  logic [1:0]       mode;
  logic [WIDTH-1:0] dout;
  logic             done;
  logic             busy;

  modport master (
    output start_valid, din, amt, mode,
    input  start_ready, dout, done, busy
  );

  modport slave (
    input  start_valid, din, amt, mode,
    output start_ready, dout, done, busy
  );
endinterface

// File: rtl/shift_seq_ctrl_step.sv
// One-bit combinational shift step (LSR/ASR/LSL, plus ROR when SHIFT_ROTATE_EN is defined).
// Zero latency and no handshake; the sequencer registers the result.
module shift_step
  import shift_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] in,
  input  shift_mode_t      mode,
  output logic [WIDTH-1:0] out
);

  always_comb begin
    out = {1'b0, in[WIDTH-1:1]};
    case (mode)
      ASR:     out = {in[WIDTH-1], in[WIDTH-1:1]};
      LSL:     out = {in[WIDTH-2:0], 1'b0};
`ifdef SHIFT_ROTATE_EN
      ROR:     out = {in[0], in[WIDTH-1:1]};
`endif
      default: out = {1'b0, in[WIDTH-1:1]};
    endcase
  end

endmodule

// File: rtl/shift_seq_ctrl.sv
// Multi-cycle shift sequencer: n = effective amount, done pulses n+2 cycles after acceptance.
// start_ready only in IDLE; requests while busy are dropped, not queued. Rotate gated by SHIFT_ROTATE_EN.
module shift_seq_ctrl
  import shift_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int AMT_W = 3
) (
  input logic              clk,
  input logic              rst_n,
  shift_seq_ctrl_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH, AMT_W);

  localparam logic [1:0] S_IDLE  = IDLE;
  localparam logic [1:0] S_SHIFT = SHIFT;
  localparam logic [1:0] S_DONE  = DONE;

  logic [1:0]       r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_dout;
  shift_mode_t      r_mode;

  shift_mode_t      w_mode;
  logic [CNT_W-1:0] w_amt_ext;
  logic [CNT_W-1:0] w_eff;
  logic [WIDTH-1:0] w_step;

  // Without rotate support, mode 11 is folded onto logical right before it is latched.
  always_comb begin
`ifdef SHIFT_ROTATE_EN
    w_mode = shift_mode_t'(bus.mode);
`else
    w_mode = (bus.mode == 2'b11) ? LSR : shift_mode_t'(bus.mode);
`endif
    w_amt_ext = CNT_W'(bus.amt);
    w_eff     = w_amt_ext;
    if ((w_mode != ROR) && (w_amt_ext > CNT_W'(WIDTH))) w_eff = CNT_W'(WIDTH);
  end

  shift_step #(.WIDTH(WIDTH)) u_step (
    .in   (r_dout),
    .mode (r_mode),
    .out  (w_step)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_dout  <= '0;
      r_mode  <= LSR;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (bus.start_valid) begin
            r_dout  <= bus.din;
            r_mode  <= w_mode;
            r_cnt   <= w_eff;
            r_state <= S_SHIFT;
          end
        end
        S_SHIFT: begin
          if (r_cnt != '0) begin
            r_dout <= w_step;
            r_cnt  <= r_cnt - CNT_W'(1);
          end else begin
            r_state <= S_DONE;
          end
        end
        S_DONE:  r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign bus.start_ready = (r_state == S_IDLE);
  assign bus.busy        = (r_state != S_IDLE);
  assign bus.done        = (r_state == S_DONE);
  assign bus.dout        = r_dout;

endmodule
